stage_pipe_skid: RTL and testbench
==================================

Name: stage_pipe_skid

Overview:
- Generic parametrised pipeline stage register with valid/ready handshake and a one-entry skid buffer; successor to the fixed-width stall/clear stage flops.
- Carries {pc, rd, data} between any two pipeline stages (EX/MA, MA/WB) and breaks the combinational ready path with no throughput loss.
- Adds a synchronous flush and a derived writeback-enable.

Parameters:
- PC_W, 64, width of pc field
- RD_W, 5, width of destination register index
- DATA_W, 64, width of data payload
- CNT_W, 32, width of optional performance counters

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous clear; drops all held entries
- in_valid  input  1  upstream entry valid
- in_ready  output  1  stage can accept an entry this cycle
- in_pc  input  PC_W  upstream pc
- in_rd  input  RD_W  upstream destination register
- in_data  input  DATA_W  upstream payload
- out_valid  output  1  output entry valid
- out_ready  input  1  downstream accepts output entry
- out_pc  output  PC_W  registered pc
- out_rd  output  RD_W  registered rd
- out_data  output  DATA_W  registered payload
- out_wb_en  output  1  out_valid and (out_rd != 0)

Behaviour:
- Storage: main register M (drives outputs) and skid register S, each with its own valid bit.
- All outputs come straight from flops; in_ready = !S.valid (registered, no combinational path from out_ready).
- Reset (rst_n low, async): M.valid=0, S.valid=0, all payload fields 0, in_ready=1, out_wb_en=0. Payload regs are reset.
- Define acc = in_valid & in_ready; drain = !M.valid | out_ready.
- Priority each rising edge:
  1. flush=1: M.valid<=0, S.valid<=0. The input is not accepted that cycle even if acc=1. Payload regs hold. Flush wins over every other event.
  2. drain & S.valid: M<=S, S.valid<=acc. acc is always 0 here, since in_ready=0.
  3. drain & !S.valid: M<=input, M.valid<=acc.
  4. !drain & acc: S<=input, S.valid<=1.
  5. Otherwise: hold.
- Latency: 1 cycle from accepted input to out_valid when M and S are empty.
- Throughput: 1 entry/cycle with out_ready held high.
- Ordering is strictly FIFO. At most 2 entries are held. in_ready falls the cycle after S fills and rises the cycle after S drains.
- Invariant: S.valid implies M.valid. An assertion covers this.
- Simultaneous in and out with M full and S empty: M is replaced by the input with no bubble.
- out_valid is held with a stable payload while out_ready=0; the bench checks this.
- Reset mid-transfer: both entries are discarded immediately and asynchronously. No entry reappears after rst_n rises.
- out_wb_en is combinational from M flops only, so rd=0 never signals a write.

Optional Feature:
- Macro STAGE_PIPE_PERF_EN.
- Defined:
  - Adds outputs perf_stall_cnt [CNT_W-1:0], which increments each cycle out_valid & !out_ready.
  - Adds perf_flush_cnt [CNT_W-1:0], which increments each cycle flush=1 while M.valid or S.valid.
  - Both reset to 0 asynchronously and wrap at 2^CNT_W-1 to 0.
- Undefined: these ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg: a stage_payload_t packed struct {pc, rd, data} built from the PC_W/RD_W/DATA_W defaults, plus constant RD_ZERO = 0.
- One natural sub-module: skid_slot, a valid+payload register with async reset, load enable and clear. It is instantiated twice, for M and S.
- Counters stay inline under the macro.

Test Plan:
- Reset/idle: hold rst_n=0 then release with in_valid=0 -> out_valid=0, in_ready=1, outputs all 0, out_wb_en=0.
- Streaming: drive pc=0x1000,0x1004,0x1008 with rd=3,0,7 on consecutive cycles, out_ready=1 -> the same sequence appears one cycle later with out_wb_en=1,0,1 and no bubbles.
- Backpressure: out_ready=0 while sending pc 0x2000 and 0x2004 -> first pc held on output, in_ready=0 after the second; raise out_ready -> 0x2000 then 0x2004 in order, in_ready=1 again.
- Flush priority: M and S full plus in_valid=1 with flush=1 -> next cycle out_valid=0, in_ready=1, incoming pc 0x3000 never emerges.
- Async reset mid-stall: both slots full, drop rst_n between edges -> out_valid=0 immediately; after release no stale pc appears.
- With STAGE_PIPE_PERF_EN: 5 stalled cycles then 1 flush with data held -> perf_stall_cnt=5, perf_flush_cnt=1; preload CNT_W=4 at 15 stalls, add one more -> wraps to 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stage register.
// Payload layout is {pc, rd, data}; RD_ZERO marks the "no destination" index.
package pipe_pkg;

    localparam int PC_W_DEF   = 64;
    localparam int RD_W_DEF   = 5;
    localparam int DATA_W_DEF = 64;

    typedef struct packed {
        logic [PC_W_DEF-1:0]   pc;
        logic [RD_W_DEF-1:0]   rd;
        logic [DATA_W_DEF-1:0] data;
    } stage_payload_t;

    localparam logic [RD_W_DEF-1:0] RD_ZERO = '0;

endpackage

// File: rtl/stage_pipe_skid_slot.sv
// skid_slot: one valid bit plus payload register.
// Clear drops the valid bit and leaves the payload untouched; a load with an
// invalid entry also leaves the payload untouched so outputs only change on
// real transfers.
module skid_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic         vld_i,
    input  logic [W-1:0] pay_i,
    output logic         vld_o,
    output logic [W-1:0] pay_o
);

    logic         vld_q;
    logic [W-1:0] pay_q;

    // Valid/payload register: clear has priority over load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            pay_q <= '0;
        end else if (clr_i) begin
            vld_q <= 1'b0;
        end else if (load_i) begin
            vld_q <= vld_i;
            if (vld_i) begin
                pay_q <= pay_i;
            end
        end
    end

    assign vld_o = vld_q;
    assign pay_o = pay_q;

endmodule

// File: rtl/stage_pipe_skid.sv
// stage_pipe_skid: valid/ready pipeline stage with a one-entry skid buffer.
// M drives the outputs, S catches the entry that arrives while M is stalled.
// in_ready is simply !S.valid, so there is no combinational path from
// out_ready back to in_ready.
// Optional feature: define STAGE_PIPE_PERF_EN to add stall/flush counters.
module stage_pipe_skid
    import pipe_pkg::*;
#(
    parameter int PC_W   = 64,
    parameter int RD_W   = 5,
    parameter int DATA_W = 64,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [RD_W-1:0]   in_rd,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [RD_W-1:0]   out_rd,
    output logic [DATA_W-1:0] out_data,
`ifdef STAGE_PIPE_PERF_EN
    output logic [CNT_W-1:0]  perf_stall_cnt,
    output logic [CNT_W-1:0]  perf_flush_cnt,
`endif
    output logic              out_wb_en
);

    localparam int PAY_W = PC_W + RD_W + DATA_W;

    logic             m_valid, s_valid;
    logic [PAY_W-1:0] m_pay, s_pay, in_pay;
    logic             acc, drain;
    logic             m_vld_d, s_load, s_vld_d;
    logic [PAY_W-1:0] m_pay_d;

    assign in_pay = {in_pc, in_rd, in_data};
    assign acc    = in_valid & in_ready;
    assign drain  = !m_valid | out_ready;

    // M is refilled whenever it drains: from S if S holds an older entry,
    // otherwise straight from the input.
    assign m_vld_d = s_valid | acc;
    assign m_pay_d = s_valid ? s_pay : in_pay;

    // S empties when it hands over to M, and fills when M is stalled.
    assign s_load  = (drain & s_valid) | (!drain & acc);
    assign s_vld_d = !drain & acc;

    skid_slot #(.W(PAY_W)) u_slot_m (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (flush),
        .load_i (drain),
        .vld_i  (m_vld_d),
        .pay_i  (m_pay_d),
        .vld_o  (m_valid),
        .pay_o  (m_pay)
    );

    skid_slot #(.W(PAY_W)) u_slot_s (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (flush),
        .load_i (s_load),
        .vld_i  (s_vld_d),
        .pay_i  (in_pay),
        .vld_o  (s_valid),
        .pay_o  (s_pay)
    );

    assign in_ready  = !s_valid;
    assign out_valid = m_valid;
    assign {out_pc, out_rd, out_data} = m_pay;
    assign out_wb_en = m_valid & (out_rd != RD_W'(RD_ZERO));

`ifdef STAGE_PIPE_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    // Stall cycles and flushes that actually discarded something; both wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (m_valid & !out_ready) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (flush & (m_valid | s_valid)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`endif

    // S only ever holds an entry younger than the one in M.
    a_skid_implies_main: assert property (@(posedge clk) disable iff (!rst_n) s_valid |-> m_valid);

endmodule

// File: tb/tb_stage_pipe_skid.sv
// Scoreboard bench for stage_pipe_skid: the driver models the stage as a
// FIFO of at most two entries and queues each accepted entry; monitors
// compare the DUT output against the queue head.
module tb_stage_pipe_skid;

    typedef struct {
        logic [63:0] pc;
        logic [4:0]  rd;
        logic [63:0] data;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_pc = '0;
    logic [4:0]  in_rd = '0;
    logic [63:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_pc;
    logic [4:0]  out_rd;
    logic [63:0] out_data;
    logic        out_wb_en;
`ifdef STAGE_PIPE_PERF_EN
    logic [31:0] perf_stall_cnt, perf_flush_cnt;
    int unsigned m_stall = 0, m_flush = 0;
`endif

    int   checks = 0;
    int   failures = 0;
    ent_t exp_q[$];
    int   held = 0;

    always #5 clk = ~clk;

    stage_pipe_skid dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_rd     (in_rd),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_rd    (out_rd),
        .out_data  (out_data),
`ifdef STAGE_PIPE_PERF_EN
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt),
`endif
        .out_wb_en (out_wb_en)
    );

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    // Negedge monitor: state flags and head-of-queue payload (also proves the
    // payload stays stable while stalled).
    always @(negedge clk) begin
        chk("out_valid", out_valid, (held > 0) ? 64'd1 : 64'd0);
        chk("in_ready", in_ready, (held < 2) ? 64'd1 : 64'd0);
        if (out_valid && exp_q.size() > 0) begin
            chk("out_pc", out_pc, exp_q[0].pc);
            chk("out_rd", 64'(out_rd), 64'(exp_q[0].rd));
            chk("out_data", out_data, exp_q[0].data);
            chk("out_wb_en", out_wb_en, (exp_q[0].rd != 0) ? 64'd1 : 64'd0);
        end
`ifdef STAGE_PIPE_PERF_EN
        chk("perf_stall", 64'(perf_stall_cnt), 64'(m_stall));
        chk("perf_flush", 64'(perf_flush_cnt), 64'(m_flush));
`endif
    end

    // Posedge monitor: retire the head on each completed output handshake.
    always @(posedge clk) begin
        if (rst_n && !flush && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("pop_nonempty", 64'd0, 64'd1);
            end else begin
                ent_t e;
                e = exp_q.pop_front();
                chk("pop_pc", out_pc, e.pc);
            end
        end
    end

    task automatic cycle(input logic v, input logic [63:0] pc, input logic [4:0] rd,
                         input logic [63:0] d, input logic ordy, input logic fl);
        int pop, push;
        ent_t e;
        @(negedge clk);
        in_valid  = v;
        in_pc     = pc;
        in_rd     = rd;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        if (rst_n) begin
`ifdef STAGE_PIPE_PERF_EN
            if (held > 0 && !ordy) m_stall++;
            if (fl && held > 0) m_flush++;
`endif
            if (fl) begin
                exp_q.delete();
                held = 0;
            end else begin
                pop  = (held > 0 && ordy) ? 1 : 0;
                push = (v && held < 2) ? 1 : 0;
                if (push != 0) begin
                    e.pc = pc; e.rd = rd; e.data = d;
                    exp_q.push_back(e);
                end
                held = held - pop + push;
            end
        end
    endtask

    task automatic async_reset();
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        held = 0;
`ifdef STAGE_PIPE_PERF_EN
        m_stall = 0; m_flush = 0;
`endif
        #1;
        chk("rst_out_valid", out_valid, 64'd0);
        chk("rst_in_ready", in_ready, 64'd1);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        logic [63:0] rp, rdat;
        logic [4:0]  rrd;
        // Reset / idle
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("idle_pc", out_pc, 64'd0);
        chk("idle_data", out_data, 64'd0);
        chk("idle_rd", 64'(out_rd), 64'd0);
        chk("idle_wb_en", out_wb_en, 64'd0);

        // Streaming
        cycle(1, 64'h1000, 5'd3, 64'hA0, 1, 0);
        cycle(1, 64'h1004, 5'd0, 64'hA1, 1, 0);
        cycle(1, 64'h1008, 5'd7, 64'hA2, 1, 0);
        cycle(0, 64'h0, 5'd0, 64'h0, 1, 0);
        cycle(0, 64'h0, 5'd0, 64'h0, 1, 0);

        // Backpressure
        cycle(1, 64'h2000, 5'd1, 64'hB0, 0, 0);
        cycle(1, 64'h2004, 5'd2, 64'hB1, 0, 0);
        cycle(1, 64'h2008, 5'd2, 64'hB2, 0, 0);
        cycle(0, 64'h0, 5'd0, 64'h0, 0, 0);
        cycle(0, 64'h0, 5'd0, 64'h0, 1, 0);
        cycle(0, 64'h0, 5'd0, 64'h0, 1, 0);
        cycle(0, 64'h0, 5'd0, 64'h0, 1, 0);

        // Flush priority over a full stage and a valid input
        cycle(1, 64'h2100, 5'd4, 64'hC0, 0, 0);
        cycle(1, 64'h2104, 5'd5, 64'hC1, 0, 0);
        cycle(1, 64'h3000, 5'd6, 64'hC2, 0, 1);
        cycle(0, 64'h0, 5'd0, 64'h0, 1, 0);
        cycle(0, 64'h0, 5'd0, 64'h0, 1, 0);

        // Async reset with both slots full
        cycle(1, 64'h4000, 5'd8, 64'hD0, 0, 0);
        cycle(1, 64'h4004, 5'd9, 64'hD1, 0, 0);
        async_reset();
        cycle(0, 64'h0, 5'd0, 64'h0, 1, 0);
        cycle(0, 64'h0, 5'd0, 64'h0, 1, 0);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            rp   = {$urandom, $urandom};
            rdat = {$urandom, $urandom};
            rrd  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            cycle(1'($urandom_range(0, 1)), rp, rrd, rdat,
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
        end

        // Bounded drain
        for (int i = 0; i < 8 && held > 0; i++) begin
            cycle(0, 64'h0, 5'd0, 64'h0, 1, 0);
        end
        @(negedge clk);
        #1;
        chk("final_empty", out_valid, 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
